udl_counter_sched: RTL and testbench

- Round-robin scheduler sharing one n-bit up/down/load counter (UDL counter) between N_REQ requesters.
- Each requester issues one command per req/ack handshake: load value, clear, or step up/down k times.
- The scheduler drives the counter's up/down/load/rst/in control pins cycle by cycle and acknowledges the requester on completion.
- Sits between client FSMs and a single UDL counter instance; counter value is not observed.

---
 rtl/udl_counter_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/udl_counter_sched.sv | 132 +++++++++++++
 tb/tb_udl_counter_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udl_counter_sched_pkg.sv
// Shared opcode and FSM state definitions for the UDL counter scheduler.
package udl_counter_sched_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above the pointer, wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_idx,
  output logic             o_valid
);

  logic [PW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = PW'((int'(i_ptr) + k) % N_REQ);
      if (!o_valid && i_req[w_j]) begin
        o_valid = 1'b1;
        o_grant = N_REQ'(1) << w_j;
        o_idx   = w_j;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/udl_counter_sched.sv
// Round-robin scheduler that shares one up/down/load counter between N_REQ
// requesters; all outputs are decoded from registered state.
module udl_counter_sched
  import udl_counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int n     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   op,
  input  logic [n*N_REQ-1:0]   arg,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 cnt_up,
  output logic                 cnt_down,
  output logic                 cnt_load,
  output logic                 cnt_rst,
  output logic [n-1:0]         cnt_in
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_idx;
  logic [1:0]    r_op;
  logic [n-1:0]  r_arg;
  logic [n-1:0]  r_rem;

  logic [N_REQ-1:0] w_grant;
  logic [PW-1:0]    w_idx;
  logic             w_valid;
  logic [1:0]       w_sel_op;
  logic [n-1:0]     w_sel_arg;
  logic             w_last;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_sel_op  = '0;
    w_sel_arg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_op  = w_sel_op  | (op[2*i +: 2]  & {2{w_grant[i]}});
      w_sel_arg = w_sel_arg | (arg[n*i +: n] & {n{w_grant[i]}});
    end
  end

  // Load/clear finish in one cycle; steps finish on the last (or only) cycle.
  assign w_last = (r_op == OP_LOAD) || (r_op == OP_CLR) || (r_rem <= n'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_valid ? EXEC : IDLE;
      EXEC:    w_state_nxt = w_last ? IDLE : EXEC;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_op  <= OP_LOAD;
      r_arg <= '0;
      r_rem <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_idx <= w_idx;
            r_op  <= w_sel_op;
            r_arg <= w_sel_arg;
            r_rem <= w_sel_arg;
          end
        end
        EXEC: begin
          if (w_last) begin
            r_ptr <= (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + PW'(1);
          end else begin
            r_rem <= r_rem - n'(1);
          end
        end
        default: r_ptr <= '0;
      endcase
    end
  end

  always_comb begin
    ack      = '0;
    busy     = 1'b0;
    cnt_up   = 1'b0;
    cnt_down = 1'b0;
    cnt_load = 1'b0;
    cnt_rst  = 1'b0;
    cnt_in   = '0;
    if (r_state == EXEC) begin
      busy = 1'b1;
      ack  = w_last ? (N_REQ'(1) << r_idx) : '0;
      case (r_op)
        OP_LOAD: begin
          cnt_load = 1'b1;
          cnt_in   = r_arg;
        end
        OP_UP:   cnt_up   = (r_rem != '0);
        OP_DOWN: cnt_down = (r_rem != '0);
        OP_CLR:  cnt_rst  = 1'b1;
        default: cnt_rst  = 1'b0;
      endcase
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_udl_counter_sched.sv
// Scoreboard bench for udl_counter_sched: per-requester command queues feed a
// handshake driver; a monitor checks every ack against the expected queue.
module tb_udl_counter_sched;
  import udl_counter_sched_pkg::*;

  localparam int NR = 4;
  localparam int W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [2*NR-1:0]   op;
  logic [W*NR-1:0]   arg;
  logic [NR-1:0]     ack;
  logic              busy, cnt_up, cnt_down, cnt_load, cnt_rst;
  logic [W-1:0]      cnt_in;

  udl_counter_sched #(.N_REQ(NR), .n(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .arg(arg), .ack(ack),
    .busy(busy), .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_load(cnt_load),
    .cnt_rst(cnt_rst), .cnt_in(cnt_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [W-1:0] arg;
    int         gap;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] arg;
  } cmd_t;

  exp_t exp_q[$];
  cmd_t cmd_q[NR][$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endfunction

  task automatic issue(int i, logic [1:0] o, logic [W-1:0] a, int gap);
    cmd_t c;
    exp_t e;
    c.op = o; c.arg = a;
    e.idx = i; e.op = o; e.arg = a; e.gap = gap;
    cmd_q[i].push_back(c);
    exp_q.push_back(e);
  endtask

  // Requester model: assert with the head command, drop req once ack is seen.
  initial begin
    req = '0; op = '0; arg = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (rst) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if (ack[i]) begin
            req[i] = 1'b0;
            if (cmd_q[i].size() > 0) void'(cmd_q[i].pop_front());
          end
        end else if (cmd_q[i].size() > 0) begin
          op[2*i +: 2]  = cmd_q[i][0].op;
          arg[W*i +: W] = cmd_q[i][0].arg;
          req[i]        = 1'b1;
        end
      end
    end
  end

  int n_up, n_down, n_load, n_rst, cyc, load_val, idle_cnt, gap_at_start;
  bit prev_busy, prev_ack;

  // Monitor: per-cycle invariants plus transaction-level compare on each ack.
  initial begin
    exp_t e;
    n_up = 0; n_down = 0; n_load = 0; n_rst = 0; cyc = 0; load_val = 0;
    idle_cnt = 1000; gap_at_start = 0; prev_busy = 1'b0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", int'({ack, busy, cnt_up, cnt_down, cnt_load, cnt_rst, cnt_in}), 0);
        n_up = 0; n_down = 0; n_load = 0; n_rst = 0; cyc = 0;
        idle_cnt = 1000; prev_busy = 1'b0; prev_ack = 1'b0;
      end else begin
        check("one_ctrl_hot", int'($countones({cnt_up, cnt_down, cnt_load, cnt_rst}) <= 1), 1);
        if (!cnt_load) check("cnt_in_zero", int'(cnt_in), 0);
        if (prev_ack) check("gap_after_ack", int'(busy), 0);
        if (busy) begin
          if (!prev_busy) gap_at_start = idle_cnt;
          cyc++;
          n_up += int'(cnt_up); n_down += int'(cnt_down);
          n_load += int'(cnt_load); n_rst += int'(cnt_rst);
          if (cnt_load) load_val = int'(cnt_in);
          if (ack != '0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_ack", int'(ack), 0);
            end else begin
              e = exp_q.pop_front();
              check("ack_idx", int'(ack), 1 << e.idx);
              case (e.op)
                OP_LOAD: begin
                  check("load_pulses", n_load, 1);
                  check("load_value", load_val, int'(e.arg));
                  check("load_stray", n_up + n_down + n_rst, 0);
                  check("load_cycles", cyc, 1);
                end
                OP_CLR: begin
                  check("clr_pulses", n_rst, 1);
                  check("clr_stray", n_up + n_down + n_load, 0);
                  check("clr_cycles", cyc, 1);
                end
                OP_UP: begin
                  check("up_pulses", n_up, int'(e.arg));
                  check("up_stray", n_down + n_load + n_rst, 0);
                  check("up_cycles", cyc, (e.arg == '0) ? 1 : int'(e.arg));
                end
                default: begin
                  check("down_pulses", n_down, int'(e.arg));
                  check("down_stray", n_up + n_load + n_rst, 0);
                  check("down_cycles", cyc, (e.arg == '0) ? 1 : int'(e.arg));
                end
              endcase
              if (e.gap >= 0) check("idle_gap", gap_at_start, e.gap);
            end
            n_up = 0; n_down = 0; n_load = 0; n_rst = 0; cyc = 0; idle_cnt = 0;
          end
        end else begin
          check("idle_quiet", int'({ack, cnt_up, cnt_down, cnt_load, cnt_rst}), 0);
          idle_cnt++;
        end
        prev_busy = busy;
        prev_ack  = (ack != '0);
      end
    end
  end

  task automatic wait_done(int budget);
    bit done;
    bit pend;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      pend = 1'b0;
      for (int i = 0; i < NR; i++) if (cmd_q[i].size() > 0) pend = 1'b1;
      if (!pend && exp_q.size() == 0 && !busy && req == '0) done = 1'b1;
    end
    check("drain_in_budget", int'(done), 1);
  endtask

  initial begin
    int pulses;
    int ri;
    logic [1:0] ro;
    logic [W-1:0] ra;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset after two up pulses abandons the command with no ack.
    begin
      cmd_t c;
      c.op = OP_UP; c.arg = 4'd5;
      cmd_q[0].push_back(c);
    end
    pulses = 0;
    for (int t = 0; t < 50 && pulses < 2; t++) begin
      @(posedge clk);
      #1;
      if (cnt_up) pulses++;
    end
    check("abort_pulses_seen", pulses, 2);
    cmd_q[0].delete();
    rst = 1'b1;
    #1;
    check("abort_outputs", int'({ack, cnt_up, cnt_down, cnt_load, cnt_rst, cnt_in}), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    issue(1, OP_LOAD, 4'hA, -1);
    wait_done(20);
    issue(2, OP_UP, 4'd3, -1);
    wait_done(20);

    // Pointer is 3 after the previous ack to requester 2.
    issue(3, OP_LOAD, 4'd1, -1);
    issue(0, OP_LOAD, 4'd1, 1);
    issue(3, OP_LOAD, 4'd2, 1);
    issue(0, OP_LOAD, 4'd2, 1);
    wait_done(40);

    issue(1, OP_CLR, 4'hF, -1);
    wait_done(20);
    issue(2, OP_UP, 4'd0, -1);
    wait_done(20);
    issue(3, OP_LOAD, 4'd5, -1);
    wait_done(20);

    // Pointer is 0: full contention gives 0,1,2,3,0.
    issue(0, OP_UP, 4'd2, -1);
    issue(1, OP_DOWN, 4'd3, 1);
    issue(2, OP_LOAD, 4'd7, 1);
    issue(3, OP_CLR, 4'd0, 1);
    issue(0, OP_DOWN, 4'd1, 1);
    wait_done(60);

    for (int k = 0; k < 500; k++) begin
      ri = $urandom_range(0, NR - 1);
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom_range(0, 15));
      issue(ri, ro, ra, -1);
      wait_done(40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
